// File: rtl/dca_lsu_wtxn_pkg.sv
// Shared types, AXI constants and width helpers for the DCA LSU write-transaction issuer.
// Optional build macro used by the issuer: DCA_WTXN_ADDR_ALIGN_CHECK_EN.
package dca_lsu_wtxn_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wtxn_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // A row may carry 0..max beats, so the field must hold max itself.
    function automatic int num_beat_width(input int max_num_axi_data);
        return $clog2(max_num_axi_data + 1);
    endfunction

    function automatic int outstanding_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/dca_lsu_outstanding_tracker.sv
// Up/down counter of AW bursts still waiting for their B response.
module dca_lsu_outstanding_tracker
    import dca_lsu_wtxn_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BW_CNT          = outstanding_width(MAX_OUTSTANDING)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [BW_CNT-1:0] count,
    output logic [BW_CNT-1:0] count_next,
    output logic              full,
    output logic              zero
);

    localparam logic [BW_CNT-1:0] CNT_MAX = BW_CNT'(MAX_OUTSTANDING);

    logic dec_eff;

    // A decrement with nothing outstanding is a stray response and is dropped.
    assign dec_eff = dec && !zero;
    assign full    = (count == CNT_MAX);
    assign zero    = (count == '0);

    always_comb begin
        count_next = count;
        if (inc && !dec_eff) begin
            count_next = count + BW_CNT'(1);
        end else if (!inc && dec_eff) begin
            count_next = count - BW_CNT'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/dca_lsu_wtxn_issuer.sv
// Store-path AW issuer: one AXI INCR burst plus one transaction-info word per matrix row.
// Build macro DCA_WTXN_ADDR_ALIGN_CHECK_EN enables beat-alignment checking of req_addr.
module dca_lsu_wtxn_issuer
    import dca_lsu_wtxn_pkg::*;
#(
    parameter int BW_AXI_ADDR      = 32,
    parameter int BW_AXI_DATA      = 32,
    parameter int BW_AXI_TID       = 4,
    parameter int MAX_NUM_AXI_DATA = 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int AWID_VALUE       = 0,
    localparam int BW_NUM_BEAT     = num_beat_width(MAX_NUM_AXI_DATA),
    localparam int BW_OUTSTANDING  = outstanding_width(MAX_OUTSTANDING)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BW_AXI_ADDR-1:0]    req_addr,
    input  logic [BW_NUM_BEAT-1:0]    req_num_beat,
    input  logic                      req_last_row,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [BW_AXI_ADDR-1:0]    awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [BW_AXI_TID-1:0]     awid,
    output logic                      txn_valid,
    input  logic                      txn_ready,
    output logic [7:0]                txn_alen,
    output logic                      txn_last_row,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    output logic [BW_OUTSTANDING-1:0] outstanding,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam logic [2:0] AW_SIZE = 3'($clog2(BW_AXI_DATA / 8));

    wtxn_state_t               state;
    logic                      last_pending;
    logic                      req_fire;
    logic                      aw_fire;
    logic                      txn_fire;
    logic                      b_fire;
    logic                      cnt_full;
    logic                      cnt_zero;
    logic [BW_OUTSTANDING-1:0] cnt_next;
    logic [BW_NUM_BEAT-1:0]    beats_m1;
    logic [BW_AXI_ADDR-1:0]    issue_addr;
    logic                      addr_misaligned;

    assign req_ready = (state == IDLE) && !cnt_full;
    assign req_fire  = req_valid && req_ready;
    assign aw_fire   = awvalid && awready;
    assign txn_fire  = txn_valid && txn_ready;
    assign bready    = !cnt_zero;
    assign b_fire    = bvalid && bready;
    assign busy      = (state != IDLE) || !cnt_zero;
    assign awid      = BW_AXI_TID'(AWID_VALUE);

    // A zero-beat row still moves one beat so the serializer always sees a WLAST.
    assign beats_m1 = (req_num_beat == '0) ? '0 : req_num_beat - BW_NUM_BEAT'(1);

`ifdef DCA_WTXN_ADDR_ALIGN_CHECK_EN
    localparam logic [BW_AXI_ADDR-1:0] ALIGN_MASK = BW_AXI_ADDR'(BW_AXI_DATA / 8 - 1);

    assign addr_misaligned = |(req_addr & ALIGN_MASK);
    assign issue_addr      = req_addr & ~ALIGN_MASK;
`else
    assign addr_misaligned = 1'b0;
    assign issue_addr      = req_addr;
`endif

    dca_lsu_outstanding_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .BW_CNT          (BW_OUTSTANDING)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .inc        (aw_fire),
        .dec        (b_fire),
        .count      (outstanding),
        .count_next (cnt_next),
        .full       (cnt_full),
        .zero       (cnt_zero)
    );

    // AW and transaction-info handshakes retire independently; leave ISSUE once both are gone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            awvalid      <= 1'b0;
            txn_valid    <= 1'b0;
            awaddr       <= '0;
            awlen        <= '0;
            awsize       <= '0;
            awburst      <= '0;
            txn_alen     <= '0;
            txn_last_row <= 1'b0;
        end else begin
            awsize  <= AW_SIZE;
            awburst <= AXI_BURST_INCR;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        awaddr       <= issue_addr;
                        awlen        <= 8'(beats_m1);
                        txn_alen     <= 8'(beats_m1);
                        txn_last_row <= req_last_row;
                        awvalid      <= 1'b1;
                        txn_valid    <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                    end
                    if (txn_fire) begin
                        txn_valid <= 1'b0;
                    end
                    if ((!awvalid || aw_fire) && (!txn_valid || txn_fire)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // done looks at the post-update count so it lines up with outstanding reaching zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pending <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                last_pending <= 1'b0;
                error        <= 1'b0;
            end
            if (last_pending && (state == IDLE) && (cnt_next == '0)) begin
                done         <= 1'b1;
                last_pending <= 1'b0;
            end
            if (req_fire && req_last_row) begin
                last_pending <= 1'b1;
            end
            if ((b_fire && (bresp != AXI_RESP_OKAY)) || (req_fire && addr_misaligned)) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dca_lsu_wtxn_issuer.sv
// Scoreboard bench for dca_lsu_wtxn_issuer; honours DCA_WTXN_ADDR_ALIGN_CHECK_EN when defined.
module tb_dca_lsu_wtxn_issuer;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        last;
    } exp_t;

`ifdef DCA_WTXN_ADDR_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_ALIGN_ADDR = 32'h0000_6000;
    localparam logic        EXP_ALIGN_ERR  = 1'b1;
`else
    localparam logic [31:0] EXP_ALIGN_ADDR = 32'h0000_6003;
    localparam logic        EXP_ALIGN_ERR  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_num_beat;
    logic        req_last_row;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        txn_valid;
    logic        txn_ready;
    logic [7:0]  txn_alen;
    logic        txn_last_row;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [2:0]  outstanding;
    logic        busy;
    logic        done;
    logic        error;

    int   total = 0;
    int   bad = 0;
    int   aw_count = 0;
    int   done_count = 0;
    int   aw_mark;
    exp_t exp_aw[$];
    exp_t exp_txn[$];
    exp_t mon_e;

    dca_lsu_wtxn_issuer dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_num_beat (req_num_beat),
        .req_last_row (req_last_row),
        .awvalid      (awvalid),
        .awready      (awready),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .awsize       (awsize),
        .awburst      (awburst),
        .awid         (awid),
        .txn_valid    (txn_valid),
        .txn_ready    (txn_ready),
        .txn_alen     (txn_alen),
        .txn_last_row (txn_last_row),
        .bvalid       (bvalid),
        .bready       (bready),
        .bresp        (bresp),
        .outstanding  (outstanding),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle; whatever is seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid && awready) begin
                aw_count++;
                if (exp_aw.size() == 0) begin
                    checkOutput("aw_unexpected", 1, 0);
                end else begin
                    mon_e = exp_aw.pop_front();
                    checkOutput("awaddr", awaddr, mon_e.addr);
                    checkOutput("awlen", awlen, mon_e.len);
                    checkOutput("awsize", awsize, 3'd2);
                    checkOutput("awburst", awburst, 2'b01);
                    checkOutput("awid", awid, 4'd0);
                end
            end
            if (txn_valid && txn_ready) begin
                if (exp_txn.size() == 0) begin
                    checkOutput("txn_unexpected", 1, 0);
                end else begin
                    mon_e = exp_txn.pop_front();
                    checkOutput("txn_alen", txn_alen, mon_e.len);
                    checkOutput("txn_last_row", txn_last_row, mon_e.last);
                end
            end
            if (done) begin
                done_count++;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] nb,
                                 input logic last, input logic [31:0] exp_addr);
        exp_t e;
        int   waited;
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            checkOutput("req_ready_timeout", req_ready, 1);
        end
        e.addr = exp_addr;
        e.len  = (nb == 3'd0) ? 8'd0 : 8'(nb - 3'd1);
        e.last = last;
        exp_aw.push_back(e);
        exp_txn.push_back(e);
        req_valid    = 1'b1;
        req_addr     = addr;
        req_num_beat = nb;
        req_last_row = last;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic sendB(input logic [1:0] resp);
        int waited;
        waited = 0;
        bvalid = 1'b1;
        bresp  = resp;
        while (!bready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bready) begin
            checkOutput("bready_timeout", bready, 1);
        end
        @(posedge clk);
        #1;
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    task automatic waitOutstanding(input logic [2:0] n);
        for (int i = 0; i < 200; i++) begin
            if (outstanding == n) break;
            @(posedge clk);
            #1;
        end
        checkOutput("outstanding_wait", outstanding, n);
    endtask

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_num_beat = '0;
        req_last_row = 1'b0;
        awready      = 1'b1;
        txn_ready    = 1'b1;
        bvalid       = 1'b0;
        bresp        = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_txn_valid", txn_valid, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_awsize", awsize, 0);
        checkOutput("rst_bready", bready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_req_ready", req_ready, 1);

        // Single last row, fully ready interconnect.
        applyStimulus(32'h0000_1000, 3'd4, 1'b1, 32'h0000_1000);
        waitOutstanding(3'd1);
        sendB(2'b00);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_error", error, 0);
        @(posedge clk);
        #1;
        checkOutput("t1_done_pulse", done, 0);

        // Fill the outstanding window with B withheld.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0000_2000 + 32'(i * 16), 3'd4, 1'b0, 32'h0000_2000 + 32'(i * 16));
        end
        waitOutstanding(3'd4);
        exp_aw.push_back('{addr: 32'h0000_2040, len: 8'd1, last: 1'b0});
        exp_txn.push_back('{addr: 32'h0000_2040, len: 8'd1, last: 1'b0});
        req_valid    = 1'b1;
        req_addr     = 32'h0000_2040;
        req_num_beat = 3'd2;
        req_last_row = 1'b0;
        checkOutput("full_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("full_req_ready_hold", req_ready, 0);
        sendB(2'b00);
        checkOutput("after_b_req_ready", req_ready, 1);
        checkOutput("after_b_outstanding", outstanding, 3);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("issue_req_ready", req_ready, 0);
        waitOutstanding(3'd4);
        for (int i = 0; i < 4; i++) begin
            sendB(2'b00);
        end
        waitOutstanding(3'd0);

        // AW stalled while the transaction-info word goes straight through.
        awready = 1'b0;
        aw_mark = aw_count;
        applyStimulus(32'h0000_3000, 3'd2, 1'b0, 32'h0000_3000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_awvalid", awvalid, 1);
        checkOutput("stall_txn_valid", txn_valid, 0);
        checkOutput("stall_req_ready", req_ready, 0);
        checkOutput("stall_aw_count", aw_count - aw_mark, 0);
        awready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_awvalid_drop", awvalid, 0);
        checkOutput("stall_back_idle", req_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_single_aw", aw_count - aw_mark, 1);
        sendB(2'b00);
        waitOutstanding(3'd0);

        // Error response on the middle row of three.
        applyStimulus(32'h0000_4000, 3'd4, 1'b0, 32'h0000_4000);
        applyStimulus(32'h0000_4010, 3'd4, 1'b0, 32'h0000_4010);
        applyStimulus(32'h0000_4020, 3'd4, 1'b1, 32'h0000_4020);
        waitOutstanding(3'd3);
        sendB(2'b00);
        checkOutput("err_before", error, 0);
        sendB(2'b10);
        checkOutput("err_set", error, 1);
        sendB(2'b00);
        checkOutput("err_done", done, 1);
        checkOutput("err_held", error, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("err_cleared", error, 0);

        // Zero-beat row, then AW and B handshakes in the same cycle.
        applyStimulus(32'h0000_5000, 3'd0, 1'b0, 32'h0000_5000);
        waitOutstanding(3'd1);
        awready = 1'b0;
        applyStimulus(32'h0000_5100, 3'd1, 1'b0, 32'h0000_5100);
        checkOutput("sim_awvalid", awvalid, 1);
        checkOutput("sim_before", outstanding, 1);
        awready = 1'b1;
        bvalid  = 1'b1;
        bresp   = 2'b00;
        @(posedge clk);
        #1;
        bvalid = 1'b0;
        checkOutput("sim_after", outstanding, 1);
        checkOutput("sim_aw_taken", awvalid, 0);
        sendB(2'b00);
        waitOutstanding(3'd0);

        // Misaligned base address.
        applyStimulus(32'h0000_6003, 3'd1, 1'b1, EXP_ALIGN_ADDR);
        checkOutput("align_err_accept", error, EXP_ALIGN_ERR);
        waitOutstanding(3'd1);
        sendB(2'b00);
        checkOutput("align_done", done, 1);
        checkOutput("align_err_final", error, EXP_ALIGN_ERR);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;

        checkOutput("aw_queue_empty", exp_aw.size(), 0);
        checkOutput("txn_queue_empty", exp_txn.size(), 0);
        checkOutput("done_total", done_count, 3);

        // Reset in the middle of an AW that is still pending.
        applyStimulus(32'h0000_7000, 3'd2, 1'b0, 32'h0000_7000);
        waitOutstanding(3'd1);
        awready = 1'b0;
        applyStimulus(32'h0000_7100, 3'd2, 1'b0, 32'h0000_7100);
        rst = 1'b1;
        #1;
        checkOutput("midrst_awvalid", awvalid, 0);
        checkOutput("midrst_txn_valid", txn_valid, 0);
        checkOutput("midrst_outstanding", outstanding, 0);
        checkOutput("midrst_busy", busy, 0);
        exp_aw.delete();
        exp_txn.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        awready = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
